move_sequencer: RTL and testbench

- Central controller between the user inputs and the game datapath.
- Accepts direction commands from debounced buttons and UART receive bytes, and queues them in a small FIFO.
- Issues moves one at a time to the game controller, then triggers a board printout over UART.
- Does not accept the next move until the printout completes, so moves and prints never overlap.

---
 rtl/move_sequencer_if.sv | 25 ++
 rtl/move_sequencer.sv | 94 +++++++++
 tb/tb_move_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: command, move and print handshake bundle for move_sequencer
interface move_sequencer_if #(
  parameter int CNT_W = 3
);
  logic             btn_valid;
  logic [2:0]       btn_dir;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic [2:0]       move_dir;
  logic             move_done;
  logic             game_rst;
  logic             print_start;
  logic             print_done;
  logic             busy;
  logic [CNT_W-1:0] fill;
  logic             dropped;
  modport master (
    output btn_valid, btn_dir, rx_valid, rx_data, move_done, print_done,
    input  move_dir, game_rst, print_start, busy, fill, dropped
  );
  modport slave (
    input  btn_valid, btn_dir, rx_valid, rx_data, move_done, print_done,
    output move_dir, game_rst, print_start, busy, fill, dropped
  );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer: queues button/UART moves, issues them then prints; MOVE_TIMEOUT_EN bounds waits
module move_sequencer #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 1000000
) (
  input logic clk,
  input logic rst,
  move_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_MOVE, GRST, PRINT, WAIT_PRINT} state_t;
  state_t           state, state_n;
  logic [1:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fill;
  logic [1:0]       cmd, rx_d, sel_d;
  logic             pending_rst, dropped;
  logic             btn_ok, btn_r, rx_ok, rx_r, btn_act, rx_act;
  logic             rst_cmd, push_req, full, push, pop, drop, tmo;
  always_comb begin
    btn_ok   = bus.btn_valid && !bus.btn_dir[2];
    btn_r    = bus.btn_valid && bus.btn_dir == 3'd5;
    rx_ok    = bus.rx_valid && (bus.rx_data inside {8'h77, 8'h64, 8'h73, 8'h61});
    rx_r     = bus.rx_valid && bus.rx_data == 8'h72;
    rx_d     = bus.rx_data == 8'h64 ? 2'd1 : bus.rx_data == 8'h73 ? 2'd2 :
               bus.rx_data == 8'h61 ? 2'd3 : 2'd0;
    btn_act  = btn_ok || btn_r;
    rx_act   = rx_ok || rx_r;
    sel_d    = btn_act ? bus.btn_dir[1:0] : rx_d;
    rst_cmd  = btn_act ? btn_r : rx_r;
    push_req = btn_ok || (rx_ok && !btn_act);
    full     = fill == CNT_W'(DEPTH);
    push     = push_req && !full && !rst_cmd;
    pop      = state == IDLE && !pending_rst && !rst_cmd && fill != '0;
    drop     = (btn_act && rx_act) || (push_req && full);
  end
`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge clk)
    if (rst || state_n != state) tmo_cnt <= '0;
    else if (state == WAIT_MOVE || state == WAIT_PRINT) tmo_cnt <= tmo_cnt + 1'b1;
  assign tmo = (state == WAIT_MOVE || state == WAIT_PRINT) && tmo_cnt == TW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = pending_rst ? GRST : pop ? ISSUE : IDLE;
      ISSUE:      state_n = WAIT_MOVE;
      WAIT_MOVE:  state_n = bus.move_done ? PRINT : tmo ? IDLE : WAIT_MOVE;
      GRST:       state_n = PRINT;
      PRINT:      state_n = WAIT_PRINT;
      WAIT_PRINT: state_n = (bus.print_done || tmo) ? IDLE : WAIT_PRINT;
      default:    state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.move_dir    = state == ISSUE ? {1'b0, cmd} : 3'd4;
    bus.game_rst    = state == GRST;
    bus.print_start = state == PRINT;
    bus.busy        = state != IDLE;
    bus.fill        = fill;
    bus.dropped     = dropped;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= sel_d;
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      cmd         <= '0;
      pending_rst <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      state <= state_n;
      if (rst_cmd) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fill <= fill + CNT_W'(push) - CNT_W'(pop);
      end
      if (pop) cmd <= mem[rd_ptr];
      pending_rst <= rst_cmd || (pending_rst && state != GRST);
      dropped     <= dropped || drop || tmo;
    end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed checks of queueing, decode, overflow, reset command and timeout
module tb_move_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int moves[$];
  int n_grst = 0;
  int n_prints = 0;
  move_sequencer_if #(.CNT_W(3)) bus ();
  move_sequencer #(.DEPTH(4), .CNT_W(3), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst) begin
      if (bus.move_dir != 3'd4) moves.push_back(int'(bus.move_dir));
      if (bus.game_rst) n_grst++;
      if (bus.print_start) n_prints++;
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_log();
    moves.delete();
    n_grst = 0;
    n_prints = 0;
  endtask
  task automatic do_reset();
    bus.btn_valid = 0; bus.btn_dir = 0; bus.rx_valid = 0; bus.rx_data = 0;
    bus.move_done = 0; bus.print_done = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    clear_log();
  endtask
  task automatic send_btn(input logic [2:0] d);
    bus.btn_valid = 1; bus.btn_dir = d;
    tick();
    bus.btn_valid = 0;
  endtask
  task automatic send_rx(input logic [7:0] b);
    bus.rx_valid = 1; bus.rx_data = b;
    tick();
    bus.rx_valid = 0;
  endtask
  task automatic drain();
    int i = 0;
    bus.move_done = 1; bus.print_done = 1;
    do begin
      tick();
      i++;
    end while ((bus.busy || bus.fill != 0) && i < 200);
    bus.move_done = 0; bus.print_done = 0;
    checks++;
    if (bus.busy || bus.fill != 0) begin
      failures++;
      $display("FAIL drain_timeout busy=%0d fill=%0d required busy=0 fill=0", bus.busy, bus.fill);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.move_dir !== 3'd4) begin failures++; $display("FAIL rst_move_dir got %0d exp 4", bus.move_dir); end
    if (bus.game_rst !== 1'b0) begin failures++; $display("FAIL rst_game_rst got %0d exp 0", bus.game_rst); end
    if (bus.print_start !== 1'b0) begin failures++; $display("FAIL rst_print_start got %0d exp 0", bus.print_start); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %0d exp 0", bus.busy); end
    if (bus.fill !== 3'd0) begin failures++; $display("FAIL rst_fill got %0d exp 0", bus.fill); end
    if (bus.dropped !== 1'b0) begin failures++; $display("FAIL rst_dropped got %0d exp 0", bus.dropped); end
  endtask
  task automatic test_single_move();
    do_reset();
    send_btn(3'd2);
    checks += 2;
    if (bus.fill !== 3'd1) begin failures++; $display("FAIL single_fill got %0d exp 1", bus.fill); end
    if (bus.move_dir !== 3'd4) begin failures++; $display("FAIL single_early_dir got %0d exp 4", bus.move_dir); end
    tick();
    checks++;
    if (bus.move_dir !== 3'd2) begin failures++; $display("FAIL single_issue_dir got %0d exp 2", bus.move_dir); end
    tick();
    checks += 2;
    if (bus.move_dir !== 3'd4) begin failures++; $display("FAIL single_dir_after got %0d exp 4", bus.move_dir); end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got %0d exp 1", bus.busy); end
    repeat (4) tick();
    bus.move_done = 1;
    tick();
    bus.move_done = 0;
    checks++;
    if (bus.print_start !== 1'b1) begin failures++; $display("FAIL single_print_start got %0d exp 1", bus.print_start); end
    tick();
    repeat (8) tick();
    bus.print_done = 1;
    tick();
    bus.print_done = 0;
    tick();
    checks += 3;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got %0d exp 0", bus.busy); end
    if (n_prints != 1) begin failures++; $display("FAIL single_prints got %0d exp 1", n_prints); end
    if (moves.size() != 1) begin failures++; $display("FAIL single_moves got %0d exp 1", moves.size()); end
  endtask
  task automatic test_uart();
    do_reset();
    send_btn(3'd1);
    tick();
    tick();
    send_rx(8'h61);
    send_rx(8'h78);
    send_rx(8'h77);
    checks += 2;
    if (bus.fill !== 3'd2) begin failures++; $display("FAIL uart_fill got %0d exp 2", bus.fill); end
    if (bus.dropped !== 1'b0) begin failures++; $display("FAIL uart_dropped got %0d exp 0", bus.dropped); end
    drain();
    checks++;
    if (moves.size() != 3) begin
      failures++; $display("FAIL uart_count got %0d exp 3", moves.size());
    end else begin
      checks += 3;
      if (moves[0] != 1) begin failures++; $display("FAIL uart_move0 got %0d exp 1", moves[0]); end
      if (moves[1] != 3) begin failures++; $display("FAIL uart_move1 got %0d exp 3", moves[1]); end
      if (moves[2] != 0) begin failures++; $display("FAIL uart_move2 got %0d exp 0", moves[2]); end
    end
  endtask
  task automatic test_overflow();
    do_reset();
    send_btn(3'd0); send_btn(3'd1); send_btn(3'd2); send_btn(3'd3); send_btn(3'd0);
    checks += 2;
    if (bus.fill !== 3'd4) begin failures++; $display("FAIL ovf_fill_full got %0d exp 4", bus.fill); end
    if (bus.dropped !== 1'b0) begin failures++; $display("FAIL ovf_dropped_early got %0d exp 0", bus.dropped); end
    send_btn(3'd1);
    checks += 2;
    if (bus.fill !== 3'd4) begin failures++; $display("FAIL ovf_fill_sat got %0d exp 4", bus.fill); end
    if (bus.dropped !== 1'b1) begin failures++; $display("FAIL ovf_dropped got %0d exp 1", bus.dropped); end
    drain();
    checks += 2;
    if (bus.dropped !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %0d exp 1", bus.dropped); end
    if (moves.size() != 5) begin
      failures++; $display("FAIL ovf_count got %0d exp 5", moves.size());
    end else begin
      checks++;
      if (moves[4] != 0) begin failures++; $display("FAIL ovf_last got %0d exp 0", moves[4]); end
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (bus.dropped !== 1'b0) begin failures++; $display("FAIL ovf_rst_clear got %0d exp 0", bus.dropped); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    bus.btn_valid = 1; bus.btn_dir = 3'd1; bus.rx_valid = 1; bus.rx_data = 8'h73;
    tick();
    bus.btn_valid = 0; bus.rx_valid = 0;
    checks += 2;
    if (bus.fill !== 3'd1) begin failures++; $display("FAIL simul_fill got %0d exp 1", bus.fill); end
    if (bus.dropped !== 1'b1) begin failures++; $display("FAIL simul_dropped got %0d exp 1", bus.dropped); end
    drain();
    checks++;
    if (moves.size() != 1 || moves[0] != 1) begin
      failures++; $display("FAIL simul_moves got count %0d exp one move of dir 1", moves.size());
    end
  endtask
  task automatic test_reset_cmd();
    do_reset();
    send_btn(3'd0);
    tick();
    tick();
    send_btn(3'd1); send_btn(3'd2); send_btn(3'd3);
    checks++;
    if (bus.fill !== 3'd3) begin failures++; $display("FAIL rcmd_fill_pre got %0d exp 3", bus.fill); end
    bus.move_done = 1;
    tick();
    bus.move_done = 0;
    tick();
    clear_log();
    send_rx(8'h72);
    checks += 2;
    if (bus.fill !== 3'd0) begin failures++; $display("FAIL rcmd_flush got %0d exp 0", bus.fill); end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL rcmd_busy got %0d exp 1", bus.busy); end
    bus.print_done = 1;
    tick();
    bus.print_done = 0;
    tick();
    checks++;
    if (bus.game_rst !== 1'b1) begin failures++; $display("FAIL rcmd_game_rst got %0d exp 1", bus.game_rst); end
    tick();
    checks += 2;
    if (bus.print_start !== 1'b1) begin failures++; $display("FAIL rcmd_print got %0d exp 1", bus.print_start); end
    if (bus.game_rst !== 1'b0) begin failures++; $display("FAIL rcmd_grst_len got %0d exp 0", bus.game_rst); end
    tick();
    bus.print_done = 1;
    tick();
    bus.print_done = 0;
    repeat (5) tick();
    checks += 4;
    if (moves.size() != 0) begin failures++; $display("FAIL rcmd_moves got %0d exp 0", moves.size()); end
    if (n_grst != 1) begin failures++; $display("FAIL rcmd_grst_count got %0d exp 1", n_grst); end
    if (n_prints != 1) begin failures++; $display("FAIL rcmd_prints got %0d exp 1", n_prints); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rcmd_idle got %0d exp 0", bus.busy); end
  endtask
  task automatic test_rst_mid_wait();
    do_reset();
    send_btn(3'd3);
    tick();
    tick();
    send_btn(3'd1);
    rst = 1;
    tick();
    rst = 0;
    checks += 3;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %0d exp 0", bus.busy); end
    if (bus.fill !== 3'd0) begin failures++; $display("FAIL midrst_fill got %0d exp 0", bus.fill); end
    if (bus.move_dir !== 3'd4) begin failures++; $display("FAIL midrst_dir got %0d exp 4", bus.move_dir); end
  endtask
`ifdef MOVE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    send_btn(3'd1);
    tick();
    tick();
    repeat (15) tick();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL tmo_early got busy %0d exp 1", bus.busy); end
    tick();
    checks += 3;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL tmo_idle got busy %0d exp 0", bus.busy); end
    if (bus.dropped !== 1'b1) begin failures++; $display("FAIL tmo_dropped got %0d exp 1", bus.dropped); end
    if (n_prints != 0) begin failures++; $display("FAIL tmo_prints got %0d exp 0", n_prints); end
  endtask
`endif
  initial begin
    test_reset();
    test_single_move();
    test_uart();
    test_overflow();
    test_simultaneous();
    test_reset_cmd();
    test_rst_mid_wait();
`ifdef MOVE_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
